// File: rtl/crypto_wallet_cpu_cpu_debug_mem_access.sv
// Debug monitor memory access sequencer: turns debug-slave ocimem strobes into
// single-word RAM reads/writes, with an auto-incrementing address and a read-data register.
module crypto_wallet_cpu_cpu_debug_mem_access #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD    = 2'd1,
        S_RWAIT = 2'd2,
        S_WR    = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   mon_a_reg;
    logic [CNT_W-1:0]    wait_cnt;
    logic                rd_incr;
    logic                any_strobe;
    logic                unused_jdo;

    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign ram_addr   = mon_a_reg;
    assign unused_jdo = ^{jdo[37], jdo[2:0]};

    // Sequencer; rd_incr remembers whether the pending read advances the address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            mon_a_reg     <= '0;
            wait_cnt      <= '0;
            rd_incr       <= 1'b0;
            ram_rd        <= 1'b0;
            ram_wr        <= 1'b0;
            ram_wdata     <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            ram_rd <= 1'b0;
            ram_wr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take_action_ocimem_b) begin
                        ram_wdata     <= jdo[34:3];
                        ram_wr        <= 1'b1;
                        monitor_ready <= 1'b0;
                        state         <= S_WR;
                    end else if (take_action_ocimem_a) begin
                        mon_a_reg <= jdo[ADDR_W+16:17];
                        if (jdo[36]) begin
                            monitor_error <= 1'b0;
                        end
                        if (jdo[35]) begin
                            ram_rd        <= 1'b1;
                            rd_incr       <= 1'b0;
                            monitor_ready <= 1'b0;
                            state         <= S_RD;
                        end
                    end else if (take_no_action_ocimem_a) begin
                        ram_rd        <= 1'b1;
                        rd_incr       <= 1'b1;
                        monitor_ready <= 1'b0;
                        state         <= S_RD;
                    end
                end
                S_RD: begin
                    wait_cnt <= CNT_W'(READ_LATENCY - 1);
                    state    <= S_RWAIT;
                end
                S_RWAIT: begin
                    if (wait_cnt == '0) begin
                        MonDReg       <= ram_rdata;
                        monitor_ready <= 1'b1;
                        state         <= S_IDLE;
                        if (rd_incr) begin
                            mon_a_reg <= mon_a_reg + 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_WR: begin
                    mon_a_reg     <= mon_a_reg + 1'b1;
                    monitor_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // Commands arriving mid-access are dropped and flagged; no clear is possible here
            if (state != S_IDLE && any_strobe) begin
                monitor_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crypto_wallet_cpu_cpu_debug_mem_access.sv
// Randomized bench: two instances (read latency 1 and 3) driven by the same strobes,
// checked per command against a transaction-level model of the monitor address/data/error state.
module tb_crypto_wallet_cpu_cpu_debug_mem_access;

    localparam logic [31:0] POISON = 32'hBADC_0DE0;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        st_a, st_na, st_b;
    logic        ram_clear;
    logic [31:0] seed;

    logic [7:0]  ram_addr_s  [2];
    logic        ram_rd_s    [2];
    logic        ram_wr_s    [2];
    logic [31:0] ram_wdata_s [2];
    logic [31:0] ram_rdata_s [2];
    logic [31:0] mon_d_s     [2];
    logic        ready_s     [2];
    logic        err_s       [2];

    int n_checks;
    int n_fail;

    // Model state
    logic [7:0]  m_addr;
    logic [31:0] m_data;
    logic        m_err;
    logic [31:0] m_mem [256];
    logic        m_wr  [256];

    // Per-command observations
    int          rd_cnt [2];
    int          wr_cnt [2];
    int          busy_cnt [2];
    int          clash [2];
    logic [7:0]  rd_addr [2];
    logic [7:0]  wr_addr [2];
    logic [31:0] wr_data [2];

    // Per-command expectations
    int          exp_rd, exp_wr;
    logic [7:0]  exp_rd_addr, exp_wr_addr;
    logic [31:0] exp_wr_data;
    int          exp_busy [2];

    crypto_wallet_cpu_cpu_debug_mem_access #(.ADDR_W(8), .READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(st_a), .take_no_action_ocimem_a(st_na), .take_action_ocimem_b(st_b),
        .ram_addr(ram_addr_s[0]), .ram_rd(ram_rd_s[0]), .ram_wr(ram_wr_s[0]),
        .ram_wdata(ram_wdata_s[0]), .ram_rdata(ram_rdata_s[0]), .MonDReg(mon_d_s[0]),
        .monitor_ready(ready_s[0]), .monitor_error(err_s[0])
    );

    crypto_wallet_cpu_cpu_debug_mem_access #(.ADDR_W(8), .READ_LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(st_a), .take_no_action_ocimem_a(st_na), .take_action_ocimem_b(st_b),
        .ram_addr(ram_addr_s[1]), .ram_rd(ram_rd_s[1]), .ram_wr(ram_wr_s[1]),
        .ram_wdata(ram_wdata_s[1]), .ram_rdata(ram_rdata_s[1]), .MonDReg(mon_d_s[1]),
        .monitor_ready(ready_s[1]), .monitor_error(err_s[1])
    );

    function automatic logic [31:0] seed_word(input logic [7:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // RAM models: data valid only during the single cycle READ_LATENCY after the read edge
    for (genvar g = 0; g < 2; g++) begin : g_ram
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] mem     [256];
        logic        written [256];
        logic [7:0]  rd_pipe;
        logic [7:0]  apipe   [8];

        always @(posedge clk) begin
            apipe[0] <= ram_addr_s[g];
            for (int i = 1; i < 8; i++) apipe[i] <= apipe[i-1];
            if (ram_clear) begin
                rd_pipe <= '0;
                for (int i = 0; i < 256; i++) written[i] <= 1'b0;
            end else begin
                rd_pipe <= {rd_pipe[6:0], ram_rd_s[g]};
                if (ram_wr_s[g]) begin
                    mem[ram_addr_s[g]]     <= ram_wdata_s[g];
                    written[ram_addr_s[g]] <= 1'b1;
                end
            end
        end

        assign ram_rdata_s[g] = rd_pipe[LAT-1]
                              ? (written[apipe[LAT-1]] ? mem[apipe[LAT-1]] : seed_word(apipe[LAT-1]))
                              : POISON;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_val(input logic [7:0] a);
        return m_wr[a] ? m_mem[a] : seed_word(a);
    endfunction

    function automatic logic [37:0] mk_a(input logic [7:0] a, input logic rd, input logic clr);
        logic [63:0] r;
        r = {$urandom, $urandom};
        r[24:17] = a;
        r[35]    = rd;
        r[36]    = clr;
        return r[37:0];
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] dat);
        logic [63:0] r;
        r = {$urandom, $urandom};
        r[34:3] = dat;
        return r[37:0];
    endfunction

    task automatic drive(input logic a, input logic na, input logic b, input logic [37:0] j);
        st_a = a; st_na = na; st_b = b; jdo = j;
    endtask

    task automatic clr_stats();
        for (int d = 0; d < 2; d++) begin
            rd_cnt[d] = 0; wr_cnt[d] = 0; busy_cnt[d] = 0; clash[d] = 0;
            rd_addr[d] = '0; wr_addr[d] = '0; wr_data[d] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (ram_rd_s[d]) begin rd_cnt[d]++; rd_addr[d] = ram_addr_s[d]; end
            if (ram_wr_s[d]) begin wr_cnt[d]++; wr_addr[d] = ram_addr_s[d]; wr_data[d] = ram_wdata_s[d]; end
            if (!ready_s[d]) busy_cnt[d]++;
            if (ram_rd_s[d] && ram_wr_s[d]) clash[d]++;
        end
    endtask

    task automatic check_idle_regs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("%s MonDReg L%0d", tag, lat_of(d)), mon_d_s[d], m_data);
            check_eq($sformatf("%s ram_addr L%0d", tag, lat_of(d)), 32'(ram_addr_s[d]), 32'(m_addr));
            check_eq($sformatf("%s error L%0d", tag, lat_of(d)), 32'(err_s[d]), 32'(m_err));
            check_eq($sformatf("%s ready L%0d", tag, lat_of(d)), 32'(ready_s[d]), 32'd1);
        end
    endtask

    task automatic verify(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("%s rd_cnt L%0d", tag, lat_of(d)), 32'(rd_cnt[d]), 32'(exp_rd));
            check_eq($sformatf("%s wr_cnt L%0d", tag, lat_of(d)), 32'(wr_cnt[d]), 32'(exp_wr));
            check_eq($sformatf("%s busy L%0d", tag, lat_of(d)), 32'(busy_cnt[d]), 32'(exp_busy[d]));
            check_eq($sformatf("%s rd_wr_clash L%0d", tag, lat_of(d)), 32'(clash[d]), 32'd0);
            if (exp_rd != 0)
                check_eq($sformatf("%s rd_addr L%0d", tag, lat_of(d)), 32'(rd_addr[d]), 32'(exp_rd_addr));
            if (exp_wr != 0) begin
                check_eq($sformatf("%s wr_addr L%0d", tag, lat_of(d)), 32'(wr_addr[d]), 32'(exp_wr_addr));
                check_eq($sformatf("%s wr_data L%0d", tag, lat_of(d)), wr_data[d], exp_wr_data);
            end
        end
        check_idle_regs(tag);
    endtask

    // One command issued from idle, optional dropped strobe (inj 1=a 2=na 3=b) while busy
    task automatic run_cmd(input string tag, input logic a, input logic na, input logic b,
                           input logic [37:0] j, input int inj);
        exp_rd = 0; exp_wr = 0; exp_busy[0] = 0; exp_busy[1] = 0;
        exp_rd_addr = '0; exp_wr_addr = '0; exp_wr_data = '0;
        if (b) begin
            exp_wr = 1; exp_wr_addr = m_addr; exp_wr_data = j[34:3];
            m_mem[m_addr] = j[34:3]; m_wr[m_addr] = 1'b1;
            m_addr = m_addr + 8'd1;
            exp_busy[0] = 1; exp_busy[1] = 1;
        end else if (a) begin
            m_addr = j[24:17];
            if (j[36]) m_err = 1'b0;
            if (j[35]) begin
                exp_rd = 1; exp_rd_addr = m_addr; m_data = m_val(m_addr);
                exp_busy[0] = 1 + lat_of(0); exp_busy[1] = 1 + lat_of(1);
            end
        end else if (na) begin
            exp_rd = 1; exp_rd_addr = m_addr; m_data = m_val(m_addr);
            m_addr = m_addr + 8'd1;
            exp_busy[0] = 1 + lat_of(0); exp_busy[1] = 1 + lat_of(1);
        end
        if (inj != 0) m_err = 1'b1;

        clr_stats();
        drive(a, na, b, j);
        tick();
        if (inj != 0) begin
            drive(inj == 1, inj == 2, inj == 3, mk_a(8'($urandom), 1'b1, 1'b1));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        repeat (7) tick();
        verify(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        seed     = $urandom;
        reset_n  = 1'b0;
        ram_clear = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 256; i++) begin m_wr[i] = 1'b0; m_mem[i] = '0; end
        m_addr = '0; m_data = '0; m_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("reset ram_rd L%0d", lat_of(d)), 32'(ram_rd_s[d]), 32'd0);
            check_eq($sformatf("reset ram_wr L%0d", lat_of(d)), 32'(ram_wr_s[d]), 32'd0);
            check_eq($sformatf("reset wdata L%0d", lat_of(d)), ram_wdata_s[d], 32'd0);
        end
        check_idle_regs("reset");
        ram_clear = 1'b0;
        reset_n   = 1'b1;
        tick();

        // Read with load; address must not advance
        run_cmd("t1 load", 1'b1, 1'b0, 1'b0, mk_a(8'h10, 1'b0, 1'b0), 0);
        run_cmd("t1 write", 1'b0, 1'b0, 1'b1, mk_b(32'hDEAD_BEEF), 0);
        run_cmd("t1 read", 1'b1, 1'b0, 1'b0, mk_a(8'h10, 1'b1, 1'b0), 0);

        // Writes across the top of the address space
        run_cmd("t2 load", 1'b1, 1'b0, 1'b0, mk_a(8'hFE, 1'b0, 1'b0), 0);
        run_cmd("t2 wr0", 1'b0, 1'b0, 1'b1, mk_b(32'h1111_1111), 0);
        run_cmd("t2 wr1", 1'b0, 1'b0, 1'b1, mk_b(32'h2222_2222), 0);
        run_cmd("t2 rdFE", 1'b1, 1'b0, 1'b0, mk_a(8'hFE, 1'b1, 1'b0), 0);
        run_cmd("t2 rdFE+", 1'b0, 1'b1, 1'b0, '0, 0);
        run_cmd("t2 rdFF+", 1'b0, 1'b1, 1'b0, '0, 0);

        // Streaming reads
        run_cmd("t3 load", 1'b1, 1'b0, 1'b0, mk_a(8'h20, 1'b0, 1'b0), 0);
        for (int i = 0; i < 3; i++)
            run_cmd($sformatf("t3 rd%0d", i), 1'b0, 1'b1, 1'b0, '0, 0);

        // Dropped write while busy, then error clear
        run_cmd("t4 busy", 1'b0, 1'b1, 1'b0, '0, 3);
        run_cmd("t4 clr", 1'b1, 1'b0, 1'b0, mk_a(8'h40, 1'b0, 1'b1), 0);

        // Simultaneous strobes resolve by priority, never an error
        run_cmd("t5 b+na", 1'b0, 1'b1, 1'b1, mk_b(32'hCAFE_F00D), 0);
        run_cmd("t5 all", 1'b1, 1'b1, 1'b1, mk_b(32'h0BAD_CAFE), 0);
        run_cmd("t5 a+na", 1'b1, 1'b1, 1'b0, mk_a(8'h41, 1'b1, 1'b0), 0);

        // Randomized command stream
        for (int it = 0; it < 160; it++) begin
            logic a, na, b, busy;
            logic [37:0] j;
            int inj;
            a  = 1'($urandom_range(0, 1));
            na = 1'($urandom_range(0, 1));
            b  = ($urandom_range(0, 3) == 0);
            if (!a && !na && !b) na = 1'b1;
            j  = b ? mk_b($urandom) : mk_a(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            busy = b | (a & j[35]) | (!a & na);
            inj = (busy && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_cmd($sformatf("rnd%0d", it), a, na, b, j, inj);
        end

        // Reset while the latency-3 instance is waiting on read data
        drive(1'b0, 1'b1, 1'b0, '0);
        tick();
        drive(1'b0, 1'b0, 1'b1, mk_b(32'h5555_AAAA));
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        reset_n = 1'b0;
        #1;
        m_addr = '0; m_data = '0; m_err = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("t6 rst ram_rd L%0d", lat_of(d)), 32'(ram_rd_s[d]), 32'd0);
            check_eq($sformatf("t6 rst ram_wr L%0d", lat_of(d)), 32'(ram_wr_s[d]), 32'd0);
            check_eq($sformatf("t6 rst wdata L%0d", lat_of(d)), ram_wdata_s[d], 32'd0);
        end
        check_idle_regs("t6 rst");
        repeat (2) tick();
        reset_n = 1'b1;
        clr_stats();
        repeat (8) tick();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("t6 post rd_cnt L%0d", lat_of(d)), 32'(rd_cnt[d]), 32'd0);
            check_eq($sformatf("t6 post wr_cnt L%0d", lat_of(d)), 32'(wr_cnt[d]), 32'd0);
        end
        check_idle_regs("t6 post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
